// File: rtl/eq_mac_scheduler.sv
// Three-band FIR equaliser that time-shares one multiply-accumulate across all bands.
// Each accepted sample is convolved with N_TAPS coefficients per band, one tap per cycle.
module eq_mac_scheduler #(
    parameter int unsigned WD_IN   = 24,
    parameter int unsigned CO_WD   = 24,
    parameter int unsigned N_TAPS  = 30,
    parameter int unsigned N_BANDS = 3
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  sample_valid,
    input  logic signed [WD_IN-1:0]               sample_in,
    output logic                                  sample_ready,
    output logic [$clog2(N_BANDS*N_TAPS)-1:0]     coef_addr,
    input  logic signed [CO_WD-1:0]               coef_data,
    output logic signed [WD_IN-1:0]               band_data,
    output logic [$clog2(N_BANDS)-1:0]            band_idx,
    output logic                                  band_valid,
    output logic                                  busy,
    output logic                                  overrun
);

    localparam int unsigned AW    = $clog2(N_BANDS * N_TAPS);
    localparam int unsigned BW    = $clog2(N_BANDS);
    localparam int unsigned TW    = $clog2(N_TAPS);
    localparam int unsigned ACC_W = WD_IN + TW;
    localparam int unsigned PW    = WD_IN + CO_WD;

    typedef enum logic [1:0] {StIdle, StMac, StDrain, StOut} state_e;

    state_e                  state_q, state_d;
    logic signed [WD_IN-1:0] sbuf_q [N_TAPS];
    logic [TW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [TW-1:0]           tap_q, tap_d;
    logic [TW-1:0]           rd_idx;
    logic [BW-1:0]           band_q, band_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] term;
    logic signed [WD_IN-1:0] samp_q, samp_d;
    logic signed [PW-1:0]    prod;
    logic [AW-1:0]           coef_addr_q, coef_addr_d;
    logic [WD_IN-1:0]        band_data_q, band_data_d;
    logic [WD_IN-1:0]        sat;
    logic [BW-1:0]           band_idx_q, band_idx_d;
    logic                    band_valid_q, band_valid_d;
    logic                    overrun_q, overrun_d;
    logic                    accept;

    assign sample_ready = (state_q == StIdle);
    assign busy         = (state_q != StIdle);
    assign accept       = sample_ready & sample_valid;
    assign coef_addr    = coef_addr_q;
    assign band_data    = band_data_q;
    assign band_idx     = band_idx_q;
    assign band_valid   = band_valid_q;
    assign overrun      = overrun_q;

    // Arithmetic shift floors the scaled product; the accumulator has headroom for N_TAPS terms.
    assign prod = PW'(samp_q) * PW'(coef_data);
    assign term = ACC_W'(prod >>> (CO_WD - 1));

    always_comb begin
        if (acc_q[ACC_W-1:WD_IN-1] == {(ACC_W-WD_IN+1){acc_q[ACC_W-1]}}) begin
            sat = acc_q[WD_IN-1:0];
        end else if (acc_q[ACC_W-1]) begin
            sat = {1'b1, {(WD_IN-1){1'b0}}};
        end else begin
            sat = {1'b0, {(WD_IN-1){1'b1}}};
        end
    end

    // Tap 0 is the newest sample, so taps walk backwards from the write pointer.
    assign rd_idx = (wr_ptr_q >= tap_q) ? (wr_ptr_q - tap_q)
                                        : TW'(32'(wr_ptr_q) + N_TAPS - 32'(tap_q));

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        tap_d        = tap_q;
        band_d       = band_q;
        acc_d        = acc_q;
        samp_d       = samp_q;
        coef_addr_d  = coef_addr_q;
        band_data_d  = band_data_q;
        band_idx_d   = band_idx_q;
        band_valid_d = 1'b0;
        overrun_d    = overrun_q | (sample_valid & ~sample_ready);

        case (state_q)
            StIdle: begin
                if (sample_valid) begin
                    acc_d   = '0;
                    band_d  = '0;
                    tap_d   = '0;
                    state_d = StMac;
                end
            end
            StMac: begin
                coef_addr_d = AW'(32'(band_q) * N_TAPS + 32'(tap_q));
                samp_d      = sbuf_q[rd_idx];
                // Product of the previous issue lands one cycle later.
                if (tap_q != '0) begin
                    acc_d = acc_q + term;
                end
                if (tap_q == TW'(N_TAPS - 1)) begin
                    state_d = StDrain;
                end else begin
                    tap_d = tap_q + TW'(1);
                end
            end
            StDrain: begin
                acc_d   = acc_q + term;
                state_d = StOut;
            end
            StOut: begin
                band_valid_d = 1'b1;
                band_data_d  = sat;
                band_idx_d   = band_q;
                if (band_q == BW'(N_BANDS - 1)) begin
                    wr_ptr_d = (wr_ptr_q == TW'(N_TAPS - 1)) ? '0 : wr_ptr_q + TW'(1);
                    state_d  = StIdle;
                end else begin
                    band_d  = band_q + BW'(1);
                    tap_d   = '0;
                    acc_d   = '0;
                    state_d = StMac;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            tap_q        <= '0;
            band_q       <= '0;
            acc_q        <= '0;
            samp_q       <= '0;
            coef_addr_q  <= '0;
            band_data_q  <= '0;
            band_idx_q   <= '0;
            band_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            tap_q        <= tap_d;
            band_q       <= band_d;
            acc_q        <= acc_d;
            samp_q       <= samp_d;
            coef_addr_q  <= coef_addr_d;
            band_data_q  <= band_data_d;
            band_idx_q   <= band_idx_d;
            band_valid_q <= band_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(N_TAPS); i++) begin
                sbuf_q[i] <= '0;
            end
        end else if (accept) begin
            sbuf_q[wr_ptr_q] <= sample_in;
        end
    end

endmodule
